uart_rx_sequencer: RTL and testbench

//   Frame-level controller for the analyzer's UART capture path. Synchronises the probed rx

---
 rtl/uart_rx_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer
//   Frame-level receiver for the analyzer's UART capture path. The raw rx line
//   is synchronised, and a falling edge seen in IDLE starts a frame. The start
//   bit is confirmed at its midpoint. Data bits are then sampled once per bit
//   period, LSB first, and the stop bit is checked. Completed bytes go to the
//   readout logic over a valid/ready handshake.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (4..65535)
//   DATA_BITS     data bits per frame (5..8); 1 start bit, 1 stop bit, no parity
//
// Ports
//   clk        system clock, posedge
//   rst_n      asynchronous active-low reset
//   rx         raw probe line, asynchronous to clk, idle high
//   enable     1 = frames may be accepted; 0 = abort any frame and hold in IDLE
//   out_data   last delivered byte, LSB = first data bit, unused MSBs are 0
//   out_valid  out_data holds an undelivered byte
//   out_ready  consumer accepts when out_valid & out_ready
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    one-cycle pulse: byte completed while the previous one was still held
//   busy       1 whenever the sequencer is not in IDLE
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 5000,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int         HALF      = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state, state_next;
    logic                   rx_meta, rx_s, rx_d;
    logic [15:0]            cnt;
    logic [2:0]             idx;
    logic [DATA_BITS-1:0]   shift;

    logic bit_tick, half_tick;
    logic cnt_run, bit_sample, data_enter, stop_ok, stop_bad, load;

    // Two-flop synchroniser plus one delay stage for edge detection. The
    // flops reset to 1 so a reset never looks like a start edge.
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    assign bit_tick  = (cnt == BIT_LAST);
    assign half_tick = (cnt == HALF_LAST);

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        cnt_run    = 1'b0;
        bit_sample = 1'b0;
        data_enter = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;

        if (!enable && state != S_IDLE) begin
            // Abort: no flags and no delivery for a partial frame.
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && rx_d && !rx_s) state_next = S_START;
                end
                S_START: begin
                    cnt_run = 1'b1;
                    if (half_tick) begin
                        cnt_run = 1'b0;
                        if (!rx_s) begin
                            state_next = S_DATA;
                            data_enter = 1'b1;
                        end else begin
                            // Start bit did not hold until its midpoint: glitch.
                            state_next = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    cnt_run = !bit_tick;
                    if (bit_tick) begin
                        bit_sample = 1'b1;
                        if (idx == IDX_LAST) state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    cnt_run = !bit_tick;
                    if (bit_tick) begin
                        if (rx_s) begin
                            stop_ok    = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            stop_bad   = 1'b1;
                            state_next = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // A line held low after a bad stop bit must return high
                    // before another start edge can be recognised.
                    if (rx_s) state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // A held byte is replaced only when the slot is empty or being accepted
    // in this very cycle; otherwise the new byte is dropped as an overrun.
    assign load = stop_ok && (!out_valid || out_ready);

    // NOTE: the shift register is only a handful of flops, so it is reset
    // along with the rest of the datapath; a large RAM would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt       <= cnt_run ? cnt + 16'd1 : 16'd0;
            frame_err <= stop_bad;
            overrun   <= stop_ok && out_valid && !out_ready;

            if (data_enter)                        idx <= '0;
            else if (bit_sample && idx != IDX_LAST) idx <= idx + 3'd1;

            if (bit_sample) shift[idx] <= rx_s;

            if (load) begin
                out_data  <= 8'(shift);
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer
//   Directed bench for uart_rx_sequencer at CLKS_PER_BIT=16, DATA_BITS=8.
//   A frame-level model predicts, from the moment each start bit is driven,
//   the cycle in which the stop bit is sampled and what the handshake outputs
//   must do then. A compare process checks the model every cycle, and
//   literal expectations per scenario pin the model itself.
module tb_uart_rx_sequencer;

    localparam int CPB      = 16;
    localparam int NBITS    = 8;
    localparam int HALF     = CPB / 2;
    // Start bit driven after posedge D reaches rx_s at D+2 and is seen as an
    // edge (rx_d=1, rx_s=0) at posedge D+3.
    localparam int EDGE_LAT = 3;
    localparam int STOP_OFS = EDGE_LAT + HALF + (NBITS + 1) * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       enable;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_sequencer #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (NBITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .enable    (enable),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        int         stop_cyc;
        logic [7:0] data;
        logic       stop_ok;
    } frame_t;

    frame_t     pend[$];
    frame_t     fr;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = 8'h00;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            pend.delete();
        end else begin
            exp_ferr = 1'b0;
            exp_ovr  = 1'b0;
            if (pend.size() > 0 && pend[0].stop_cyc == cyc) begin
                fr = pend.pop_front();
                if (!fr.stop_ok) begin
                    exp_ferr = 1'b1;
                    if (exp_valid && out_ready) exp_valid = 1'b0;
                end else if (!exp_valid || out_ready) begin
                    exp_valid = 1'b1;
                    exp_data  = fr.data;
                end else begin
                    exp_ovr = 1'b1;
                end
            end else if (exp_valid && out_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    always @(negedge rst_n) begin
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        pend.delete();
    end

    // ---------------- compare + event monitor ----------------
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int first_valid_cyc = -1;

    always @(negedge clk) begin
        check("out_valid", out_valid, exp_valid);
        check("out_data",  out_data,  exp_data);
        check("frame_err", frame_err, exp_ferr);
        check("overrun",   overrun,   exp_ovr);
        if (out_valid) valid_cnt++;
        if (frame_err) ferr_cnt++;
        if (overrun)   ovr_cnt++;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        valid_cnt       = 0;
        ferr_cnt        = 0;
        ovr_cnt         = 0;
        first_valid_cyc = -1;
    endtask

    // Drives one frame. When track is set the model is told when the stop
    // bit will be sampled. abort_bit >= 0 drops enable in the middle of that
    // data bit. rx is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input bit track, input int abort_bit);
        frame_t f;
        rx = 1'b0;
        if (track) begin
            f.stop_cyc = cyc + STOP_OFS;
            f.data     = b;
            f.stop_ok  = stop_lvl;
            pend.push_back(f);
        end
        repeat (CPB) tick();
        for (int i = 0; i < NBITS; i++) begin
            rx = b[i];
            if (i == abort_bit) begin
                repeat (HALF) tick();
                check("busy_before_abort", busy, 1);
                enable = 1'b0;
                tick();
                check("busy_after_abort", busy, 0);
                repeat (CPB - HALF - 1) tick();
            end else begin
                repeat (CPB) tick();
            end
        end
        rx = stop_lvl;
        repeat (CPB) tick();
    endtask

    int d0;

    initial begin
        rst_n     = 1'b0;
        rx        = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun",   overrun,   0);
        check("rst_busy",      busy,      0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 1: single byte, consumer ready, exact stop-sample timing
        clear_mon();
        d0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b1, -1);
        repeat (4) tick();
        check("t1_latency", first_valid_cyc - d0, 155);
        check("t1_valid_width", valid_cnt, 1);
        check("t1_data", out_data, 8'hA5);
        check("t1_idle", busy, 0);

        // 2: back-to-back frames with the consumer stalled
        out_ready = 1'b0;
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        send_frame(8'hC3, 1'b1, 1'b1, -1);
        repeat (4) tick();
        check("t2_overrun_cnt", ovr_cnt, 1);
        check("t2_held_valid", out_valid, 1);
        check("t2_held_data", out_data, 8'h3C);
        out_ready = 1'b1;
        repeat (2) tick();
        check("t2_drained", out_valid, 0);

        // 3: bad stop bit, line then held low
        repeat (5) tick();
        clear_mon();
        send_frame(8'h55, 1'b0, 1'b1, -1);
        repeat (20) tick();
        check("t3_ferr_cnt", ferr_cnt, 1);
        check("t3_no_valid", valid_cnt, 0);
        check("t3_busy_low_line", busy, 1);
        rx = 1'b1;
        repeat (4) tick();
        check("t3_busy_released", busy, 0);

        // 4: 4-cycle glitch on the idle line
        repeat (5) tick();
        clear_mon();
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        check("t4_busy_in_start", busy, 1);
        repeat (10) tick();
        check("t4_back_idle", busy, 0);
        repeat (20) tick();
        check("t4_no_valid", valid_cnt, 0);
        check("t4_no_flags", ferr_cnt + ovr_cnt, 0);

        // 5: enable dropped mid-DATA, then a clean frame
        clear_mon();
        send_frame(8'hFF, 1'b1, 1'b0, 2);
        repeat (4) tick();
        check("t5_no_delivery", valid_cnt, 0);
        enable = 1'b1;
        repeat (4) tick();
        send_frame(8'h01, 1'b1, 1'b1, -1);
        repeat (4) tick();
        check("t5_next_valid_cnt", valid_cnt, 1);
        check("t5_next_data", out_data, 8'h01);

        // 6: asynchronous reset mid-frame with a byte held
        out_ready = 1'b0;
        send_frame(8'h42, 1'b1, 1'b1, -1);
        repeat (4) tick();
        check("t6_held_before", out_valid, 1);
        rx = 1'b0;
        repeat (40) tick();
        check("t6_busy_mid_frame", busy, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data",  out_data,  0);
        check("t6_rst_flags", {frame_err, overrun}, 0);
        check("t6_rst_busy",  busy, 0);
        rx = 1'b1;
        repeat (5) tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) tick();
        clear_mon();
        send_frame(8'h81, 1'b1, 1'b1, -1);
        repeat (4) tick();
        check("t6_next_valid_cnt", valid_cnt, 1);
        check("t6_next_data", out_data, 8'h81);
        check("t6_queue_empty", pend.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
